// File: rtl/pc_redirect_scheduler_pkg.sv
// Shared types and constants for the fetch-PC redirect scheduler and its
// branch-training queue.
package pc_redirect_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_JALR = 2'd1,
        ST_FLUSH     = 2'd2
    } sched_state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    // A training entry is the table index plus the taken/not-taken bit.
    function automatic int upd_entry_w(input int idx_w);
        return idx_w + 1;
    endfunction

    // Bits needed to hold the value n (at least one bit).
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) <= n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pc_redirect_scheduler_upd_fifo.sv
// Synchronous FIFO holding pending predictor-training writes; a push while
// full is accepted only when a pop frees the head slot on the same edge.
module pc_redirect_scheduler_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the index/taken outputs are clean.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_redirect_scheduler.sv
// Owns the fetch PC: arbitrates rollback, JALR resolution, decoder redirects
// and sequential advance, and serialises branch training onto one update port.
module pc_redirect_scheduler
    import pc_redirect_scheduler_pkg::*;
#(
    parameter int IDX_W        = 7,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             fetch_ack_in,
    input  logic             dec_is_jal_in,
    input  logic             dec_is_jalr_in,
    input  logic             dec_is_branch_in,
    input  logic             dec_pred_taken_in,
    input  logic [31:0]      dec_imm_in,
    input  logic             rob_commit_in,
    input  logic             rob_is_jalr_in,
    input  logic             rob_is_branch_in,
    input  logic [31:0]      rob_pc_in,
    input  logic             rob_taken_in,
    input  logic [31:0]      rob_target_in,
    input  logic             roll_back_in,
    output logic [31:0]      pc_out,
    output logic             fetch_en_out,
    output logic             upd_valid_out,
    output logic [IDX_W-1:0] upd_idx_out,
    output logic             upd_taken_out,
    input  logic             upd_ready_in,
    output logic [7:0]       upd_drop_cnt_out
);

    localparam int ENTRY_W = upd_entry_w(IDX_W);
    localparam int CNT_W   = cnt_w(FLUSH_CYCLES);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [31:0]      pc;
    logic [31:0]      pc_nxt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_nxt;
    logic             enq;
    logic [ENTRY_W-1:0] enq_data;
    logic             deq;
    logic             q_full;
    logic             q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic             drop;
    logic [7:0]       drop_cnt;
    logic             unused_rob_pc_bits;

    assign unused_rob_pc_bits = ^{rob_pc_in[31:IDX_W+2], rob_pc_in[1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Rollback wins outright; otherwise a branch commit may enqueue alongside
    // whatever the current state does with the PC.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        flush_cnt_nxt = flush_cnt;
        enq           = FALSE;
        enq_data      = {rob_pc_in[IDX_W+1:2], rob_taken_in};

        if (rdy_in) begin
            if (roll_back_in) begin
                pc_nxt        = rob_target_in;
                state_nxt     = ST_FLUSH;
                flush_cnt_nxt = CNT_W'(FLUSH_CYCLES);
                enq           = rob_is_branch_in;
            end else begin
                if (rob_commit_in && rob_is_branch_in) begin
                    enq = TRUE;
                end
                case (state)
                    ST_RUN: begin
                        if (fetch_ack_in) begin
                            if (dec_is_jal_in) begin
                                pc_nxt = pc + dec_imm_in;
                            end else if (dec_is_jalr_in) begin
                                state_nxt = ST_WAIT_JALR;
                            end else if (dec_is_branch_in && dec_pred_taken_in) begin
                                pc_nxt = pc + dec_imm_in;
                            end else begin
                                pc_nxt = pc + PC_STEP;
                            end
                        end
                    end
                    ST_WAIT_JALR: begin
                        if (rob_commit_in && rob_is_jalr_in) begin
                            pc_nxt    = rob_target_in;
                            state_nxt = ST_RUN;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt <= CNT_W'(1)) begin
                            flush_cnt_nxt = '0;
                            state_nxt     = ST_RUN;
                        end else begin
                            flush_cnt_nxt = flush_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = ST_RUN;
                    end
                endcase
            end
        end
    end

    assign deq  = rdy_in && !q_empty && upd_ready_in;
    assign drop = enq && q_full && !deq;

    pc_redirect_scheduler_upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (enq),
        .push_data (enq_data),
        .pop       (deq),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign pc_out           = pc;
    assign fetch_en_out     = (state == ST_RUN);
    assign upd_valid_out    = !q_empty;
    assign upd_idx_out      = q_head[ENTRY_W-1:1];
    assign upd_taken_out    = q_head[0];
    assign upd_drop_cnt_out = drop_cnt;

endmodule

// File: doc/pc_redirect_scheduler.md
# pc_redirect_scheduler

Owns the fetch PC and schedules every redirect source onto it: ROB rollback, committed JALR resolution, decoder-side JAL/predicted-branch redirects, and sequential advance. It also serialises branch-outcome training writes onto the predictor table's single update port. A small queue absorbs back-pressure on that port. Sits between fetch, decoder, ROB and the predictor table.

## Interface
- IDX_W, 7: predictor table index width; index = pc[IDX_W+1:2]
- UPD_DEPTH, 4: training queue depth (power of 2, ≥2)
- FLUSH_CYCLES, 1: fetch bubble length after rollback (≥1)

- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes all state
- fetch_ack_in  in  1  fetch consumed pc_out this cycle; qualifies dec_* fields
- dec_is_jal_in / dec_is_jalr_in / dec_is_branch_in  in  1 each  class of instruction at pc_out
- dec_pred_taken_in  in  1  predictor lookup result for pc_out
- dec_imm_in  in  32  sign-extended immediate
- rob_commit_in  in  1  ROB commits one entry
- rob_is_jalr_in / rob_is_branch_in  in  1 each  class of committed entry
- rob_pc_in  in  32  PC of committed/rolled-back entry
- rob_taken_in  in  1  actual branch outcome
- rob_target_in  in  32  resolved next PC (JALR target or rollback target)
- roll_back_in  in  1  misprediction; entry described by rob_* fields
- pc_out  out  32  current fetch PC
- fetch_en_out  out  1  fetch may issue at pc_out
- upd_valid_out  out  1  training write pending
- upd_idx_out  out  IDX_W  table index to train
- upd_taken_out  out  1  increment (1) / decrement (0) counter
- upd_ready_in  in  1  table accepts write this cycle
- upd_drop_cnt_out  out  8  saturating count of dropped training writes

## Operation
- FSM states: RUN, WAIT_JALR, FLUSH. fetch_en_out = (state==RUN).
- Reset (rst_in low, async): pc_out=0, state=RUN, flush counter=0, queue empty, upd_valid_out=0, upd_idx_out=0, upd_taken_out=0, upd_drop_cnt_out=0.
- rdy_in low: nothing changes (PC, FSM, queue, counter); inputs ignored.
- Per-cycle priority with rdy_in high:
  - roll_back_in: pc_out←rob_target_in; state←FLUSH, counter←FLUSH_CYCLES; if rob_is_branch_in, enqueue {rob_pc_in[IDX_W+1:2], rob_taken_in}. Decoder and rob_commit_in ignored this cycle.
  - rob_commit_in & rob_is_jalr_in & state==WAIT_JALR: pc_out←rob_target_in, state←RUN.
  - rob_commit_in & rob_is_branch_in: enqueue training write. Coexists with the decoder action below.
  - state==RUN & fetch_ack_in:
    - JAL: pc_out←pc_out+dec_imm_in.
    - JALR: pc_out held, state←WAIT_JALR.
    - Branch: pc_out ← dec_pred_taken_in ? pc_out+dec_imm_in : pc_out+4.
    - Otherwise: pc_out+4.
  - Additions are 32-bit modulo; wrap-around is not flagged.
  - FLUSH: counter decrements each cycle; on reaching 0 → RUN.
  - rob_commit_in JALR outside WAIT_JALR: no PC effect.
- Training queue: at most one enqueue per cycle. upd_valid_out = !empty, head drives upd_idx_out/upd_taken_out. Dequeue on upd_valid_out & upd_ready_in.
  - Full & enqueue & no dequeue: the write is dropped and upd_drop_cnt_out increments, saturating at 255.
  - Full & enqueue & dequeue: the write is accepted.

## Timing
- All outputs are registered or decoded from registered state; no input→output combinational path.
- Redirect/advance at edge N is visible on pc_out at N+1.
- Rollback at N: fetch_en_out low N+1 … N+FLUSH_CYCLES, high at N+FLUSH_CYCLES+1 with pc_out=target.
- JALR: fetch_en_out low from the cycle after the ack until the cycle after the resolving commit.
- Enqueue at N to an empty queue gives upd_valid_out at N+1; there is no bypass.
- Reset asserted mid-operation discards pending writes and any WAIT_JALR/FLUSH state immediately.

## Structure
- Shared include (alongside the op-type defines): state encodings, TRUE/FALSE, training-entry width (IDX_W+1).
- One sub-module: upd_fifo, a parameterised synchronous FIFO with width, depth, full/empty, and the same async active-low reset.

## Test plan
- Reset, fetch_ack_in ×3 non-branch → pc_out 0→4→8→12, fetch_en_out=1 throughout.
- pc=0x100, ack with JALR → fetch_en_out=0. Two idle cycles, then commit JALR target 0x2000 → next cycle pc_out=0x2000, fetch_en_out=1.
- pc=0x40, ack branch taken with imm=-16 → pc=0x30. Same cycle rollback target 0x44, FLUSH_CYCLES=1 → pc=0x44, fetch_en_out low exactly one cycle.
- upd_ready_in=0, six branch commits (pc 0x0,0x4,…,0x14) → 4 queued, upd_drop_cnt_out=2. Raise ready → idx 0,1,2,3 drained one per cycle.
- Full queue, simultaneous enqueue+dequeue → no drop, count stays 4. rdy_in low 3 cycles with ack pulses → pc_out and queue unchanged.
- Assert rst_in low mid-WAIT_JALR with queue non-empty → pc_out=0, state RUN, upd_valid_out=0 without waiting for a clock edge.
